// File: rtl/mawg_cfg_ctrl.sv
// rtl/mawg_cfg_ctrl.sv - MAWG command-frame decoder with shadow/active config bank
// Frames: 1 command byte + 4 payload bytes MSB first; COMMIT swaps shadow into active atomically.
module mawg_cfg_ctrl #(
   parameter int TIMEOUT_CYC = 50000,
   parameter bit AUTO_COMMIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic [1:0]  out_sel,
   output logic [1:0]  wave_sel,
   output logic [31:0] freq_ctrl,
   output logic        chirp_is_down,
   output logic [3:0]  chirp_delay,
   output logic [31:0] chirp_min_ctrl,
   output logic [31:0] chirp_max_ctrl,
   output logic [31:0] chirp_inc_rate,
   output logic [31:0] chirp_div_rate,
   output logic [31:0] pulse_duty_cycle,
   output logic [31:0] fm_ctr_ctrl,
   output logic [7:0]  fm_deviation,
   output logic [4:0]  fm_demod_rate,
   output logic        busy,
   output logic        cmd_done,
   output logic        cmd_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, PAYLOAD, EXEC} state_t;

   typedef struct packed {
      logic [1:0]  out_sel;
      logic [1:0]  wave_sel;
      logic [31:0] freq_ctrl;
      logic        chirp_is_down;
      logic [3:0]  chirp_delay;
      logic [31:0] chirp_min_ctrl;
      logic [31:0] chirp_max_ctrl;
      logic [31:0] chirp_inc_rate;
      logic [31:0] chirp_div_rate;
      logic [31:0] pulse_duty_cycle;
      logic [31:0] fm_ctr_ctrl;
      logic [7:0]  fm_deviation;
      logic [4:0]  fm_demod_rate;
   } cfg_t;

   state_t        state, state_next;
   logic [1:0]    byte_cnt, byte_next;
   logic [TW-1:0] tmo_cnt, tmo_next;
   logic [7:0]    cmd, cmd_next;
   logic [31:0]   pay_buf, buf_next;
   logic          timeout;
   cfg_t          shadow, active;
   logic          wr_ok;

   function automatic cfg_t apply_wr(input cfg_t c, input logic [7:0] op, input logic [31:0] p);
      cfg_t r;
      r = c;
      case (op)
         8'h00: r.out_sel          = p[1:0];
         8'h01: r.wave_sel         = p[1:0];
         8'h02: r.freq_ctrl        = p;
         8'h03: r.chirp_is_down    = p[0];
         8'h04: r.chirp_delay      = p[3:0];
         8'h05: r.chirp_min_ctrl   = p;
         8'h06: r.chirp_max_ctrl   = p;
         8'h07: r.chirp_div_rate   = p;
         8'h08: r.chirp_inc_rate   = p;
         8'h09: r.pulse_duty_cycle = p;
         8'h0A: r.fm_ctr_ctrl      = p;
         8'h0B: r.fm_deviation     = p[7:0];
         8'h0C: r.fm_demod_rate    = p[4:0];
         default: ;
      endcase
      return r;
   endfunction

   assign wr_ok = (cmd <= 8'h0C);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         byte_cnt <= '0;
         tmo_cnt  <= '0;
         cmd      <= '0;
         pay_buf  <= '0;
      end else begin
         state    <= state_next;
         byte_cnt <= byte_next;
         tmo_cnt  <= tmo_next;
         cmd      <= cmd_next;
         pay_buf  <= buf_next;
      end
   end

   always_comb begin
      state_next = state;
      byte_next  = byte_cnt;
      tmo_next   = tmo_cnt;
      cmd_next   = cmd;
      buf_next   = pay_buf;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               cmd_next   = rx_data;
               state_next = PAYLOAD;
               byte_next  = '0;
               tmo_next   = '0;
            end
         end
         PAYLOAD: begin
            if (rx_valid) begin
               buf_next = {pay_buf[23:0], rx_data};
               tmo_next = '0;
               if (byte_cnt == 2'd3) begin
                  state_next = EXEC;
                  byte_next  = '0;
               end else begin
                  byte_next = byte_cnt + 2'd1;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               state_next = IDLE;
               timeout    = 1'b1;
               tmo_next   = '0;
               byte_next  = '0;
               buf_next   = '0;
            end else begin
               tmo_next = tmo_cnt + TW'(1);
            end
         end
         EXEC: begin
            // A byte arriving in the execute cycle is the next frame's command.
            if (rx_valid) begin
               cmd_next   = rx_data;
               state_next = PAYLOAD;
               byte_next  = '0;
               tmo_next   = '0;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         shadow   <= '0;
         active   <= '0;
         cmd_done <= 1'b0;
         cmd_err  <= 1'b0;
      end else begin
         cmd_done <= 1'b0;
         cmd_err  <= timeout;
         if (state == EXEC) begin
            if (cmd == 8'h0E) begin
               active   <= shadow;
               cmd_done <= 1'b1;
            end else if (cmd == 8'h0F) begin
               shadow   <= '0;
               active   <= '0;
               cmd_done <= 1'b1;
            end else if (wr_ok) begin
               shadow <= apply_wr(shadow, cmd, pay_buf);
               if (AUTO_COMMIT)
                  active <= apply_wr(active, cmd, pay_buf);
               cmd_done <= 1'b1;
            end else begin
               cmd_err <= 1'b1;
            end
         end
      end
   end

   assign busy             = (state == PAYLOAD) || (state == EXEC);
   assign out_sel          = active.out_sel;
   assign wave_sel         = active.wave_sel;
   assign freq_ctrl        = active.freq_ctrl;
   assign chirp_is_down    = active.chirp_is_down;
   assign chirp_delay      = active.chirp_delay;
   assign chirp_min_ctrl   = active.chirp_min_ctrl;
   assign chirp_max_ctrl   = active.chirp_max_ctrl;
   assign chirp_inc_rate   = active.chirp_inc_rate;
   assign chirp_div_rate   = active.chirp_div_rate;
   assign pulse_duty_cycle = active.pulse_duty_cycle;
   assign fm_ctr_ctrl      = active.fm_ctr_ctrl;
   assign fm_deviation     = active.fm_deviation;
   assign fm_demod_rate    = active.fm_demod_rate;

endmodule

// File: doc/mawg_cfg_ctrl.md
Name: mawg_cfg_ctrl

Overview:
- Byte-stream command decoder and configuration register bank for the MAWG waveform core.
- Receives 5-byte command frames from the UART receiver: 1 command byte, then 4 payload bytes, MSB first.
- Writes go to a shadow register set and are transferred to the active set (driving MAWG) atomically, so multi-field retunes never glitch.
- Adds an inter-byte timeout, unknown-command rejection and done/error status pulses.

Parameters:
- TIMEOUT_CYC, 50000: clk cycles allowed between bytes of one frame before the frame is discarded.
- AUTO_COMMIT, 0: 1 = each register write updates shadow and active in the same cycle; 0 = active changes only on a COMMIT command.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte.
- rx_data  in  8  received byte.
- out_sel  out  2  active output select.
- wave_sel  out  2  active waveform select.
- freq_ctrl  out  32  active phase-increment word.
- chirp_is_down  out  1  active chirp direction.
- chirp_delay  out  4  active chirp delay.
- chirp_min_ctrl, chirp_max_ctrl, chirp_inc_rate, chirp_div_rate  out  32 each  active chirp settings.
- pulse_duty_cycle  out  32  active pulse duty.
- fm_ctr_ctrl  out  32  active FM centre word.
- fm_deviation  out  8  active FM deviation.
- fm_demod_rate  out  5  active FM rate.
- busy  out  1  high while a frame is in progress (states PAYLOAD and EXEC).
- cmd_done  out  1  one-cycle pulse when a valid frame executes.
- cmd_err  out  1  one-cycle pulse on timeout or unknown command.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All shadow and active registers are 0.
  - State is IDLE; byte counter is 0; timeout counter is 0.
  - busy, cmd_done and cmd_err are 0.
  - Reset has priority over everything and aborts any frame in progress.
- IDLE:
  - rx_valid latches rx_data into cmd and moves to PAYLOAD with byte count 0.
- PAYLOAD:
  - Each rx_valid shifts the byte into a 32-bit buffer (buf <= {buf[23:0], rx_data}), increments the count and clears the timeout counter.
  - On the 4th byte, moves to EXEC.
  - The timeout counter increments on every cycle without rx_valid.
  - If the timeout counter reaches TIMEOUT_CYC-1 with no byte, the next state is IDLE: cmd_err pulses, no register changes, and the buffer is discarded.
- EXEC (exactly one cycle), decoded on cmd, with payload P = assembled 32-bit value:
  - 0x0 out_sel = P[1:0]
  - 0x1 wave_sel = P[1:0]
  - 0x2 freq_ctrl = P
  - 0x3 chirp_is_down = P[0]
  - 0x4 chirp_delay = P[3:0]
  - 0x5 chirp_min_ctrl = P
  - 0x6 chirp_max_ctrl = P
  - 0x7 chirp_div_rate = P
  - 0x8 chirp_inc_rate = P
  - 0x9 pulse_duty_cycle = P
  - 0xA fm_ctr_ctrl = P
  - 0xB fm_deviation = P[7:0]
  - 0xC fm_demod_rate = P[4:0]
  - 0xE COMMIT: all shadow registers copy to active in the same edge; payload ignored.
  - 0xF CLEAR: shadow and active are all zeroed; payload ignored.
  - 0x0–0xC write the shadow register; with AUTO_COMMIT=1 they also write the matching active register.
  - 0xE, 0xF and valid writes pulse cmd_done.
  - Any other cmd (0xD, 0x10–0xFF) pulses cmd_err, writes nothing, and still consumes 4 payload bytes.
- Latency:
  - 4th payload byte accepted at edge N.
  - Register update and cmd_done/cmd_err pulse at edge N+1.
  - State is IDLE after N+1.
- rx_valid during EXEC is accepted as the next command byte (EXEC goes straight to PAYLOAD); no byte is ever dropped.
- Frames are not aborted by command content. The only abort paths are timeout and reset.
- cmd_done and cmd_err are never high in the same cycle.
- Active outputs are registered and change only at EXEC edges or reset.

Test Plan:
1. Reset, then frame 02 00 01 00 00 and no commit → freq_ctrl stays 0, cmd_done pulses once. Then frame 0E 00 00 00 00 → freq_ctrl = 0x00010000 at the edge after the last byte.
2. Frames 05 00 00 10 00, 06 00 00 20 00, then 0E xx xx xx xx → chirp_min_ctrl 0x1000 and chirp_max_ctrl 0x2000 update in the same cycle.
3. Send 02 AA BB, then idle TIMEOUT_CYC cycles → cmd_err pulses once, busy drops, no register changes. The next frame 01 00 00 00 03 then decodes correctly (wave_sel shadow = 3).
4. Frame 0D 11 22 33 44 → cmd_err, no write. Then frame 0F 00 00 00 00 after nonzero config → all outputs 0, cmd_done pulses.
5. With AUTO_COMMIT=1, frame 0B 00 00 00 7F → fm_deviation = 0x7F one cycle after the last byte, with no commit needed.
6. Drive rst=0 mid-frame after 2 payload bytes, then send a full frame → state restarts in IDLE and the new frame executes correctly. Also send back-to-back frames with rx_valid asserted during EXEC → both execute.
